// File: rtl/discipline_pkg.sv
// Shared types and constants for the GPS discipline sequencer.
// State encoding is fixed so Seq_State can be decoded by software.
// PWM_DUTY_HALF is the free-running mid-scale duty word.
package discipline_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    TRACK  = 3'd2,
    LOCK   = 3'd3,
    HOLD   = 3'd4
  } seq_state_e;

  localparam logic [15:0] PWM_DUTY_HALF = 16'd32768;

  // States in which samples are handed to the loop filter.
  function automatic logic is_tracking(input seq_state_e s);
    return (s == TRACK) || (s == LOCK);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one register stage holds the previous level.
// Latency: rise_o is high for exactly one cycle, the cycle the input is first seen high.
// No backpressure; the input is assumed synchronous to clk_i.
module edge_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember last cycle's level so a 0->1 change can be spotted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/discipline_seq.sv
// GPS discipline sequencer: IDLE -> WARMUP -> TRACK -> LOCK, with optional HOLD.
// Loop_Update pulses in the sample cycle; PWM_Duty loads Loop_Duty one cycle later.
// Optional holdover (HOLD state, Hold_Duty register) enabled by macro DISCIPLINE_HOLDOVER_EN.
module discipline_seq
  import discipline_pkg::*;
#(
  parameter int          WARMUP_N  = 16,
  parameter logic [15:0] LOCK_TH   = 16'd8,
  parameter int          LOCK_N    = 8,
  parameter logic [15:0] UNLOCK_TH = 16'd200,
  parameter logic [23:0] WDOG_CYC  = 24'd12_000_000
) (
  input  logic        CLK_Sys,
  input  logic        CLK_Rst,
  input  logic        GPS_Exist,
  input  logic        Flag_Measure_Done,
  input  logic        Flag_Measure_Dir,
  input  logic [15:0] Phase_Out,
  input  logic [15:0] Loop_Duty,
  output logic        Loop_Update,
  output logic [15:0] PWM_Duty,
  output logic [2:0]  Seq_State,
  output logic        Locked
);

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_N - 1);
  localparam logic [15:0] LOCK_CNT  = 16'(LOCK_N);

  seq_state_e  state_q;
  logic [15:0] samp_cnt_q;
  logic [15:0] good_cnt_q;
  logic [15:0] pwm_q;
  logic [23:0] wdog_q;
  logic        upd_q;

  logic        sample;
  logic        wdog_exp;
  logic        gps_loss;
  logic        tracking;
  logic        load_now;
  logic        good_smp;
  logic [15:0] good_inc;

  // Direction only tells the loop filter which way to steer; sequencing ignores it.
  logic dir_unused;
  assign dir_unused = Flag_Measure_Dir;

  edge_rise u_edge (
    .clk_i (CLK_Sys),
    .rst_ni(CLK_Rst),
    .d_i   (Flag_Measure_Done),
    .rise_o(sample)
  );

  assign wdog_exp = (wdog_q >= WDOG_CYC);
  assign gps_loss = ~GPS_Exist | wdog_exp;
  assign tracking = is_tracking(state_q);
  // Loss beats a coincident sample: the sample is simply dropped.
  assign Loop_Update = sample & tracking & ~gps_loss;
  // upd_q marks the cycle after a pulse, when the filter's new duty word is taken.
  assign load_now = upd_q & tracking;
  assign good_smp = (Phase_Out <= LOCK_TH);
  assign good_inc = (good_cnt_q >= LOCK_CNT) ? LOCK_CNT : good_cnt_q + 16'd1;

`ifdef DISCIPLINE_HOLDOVER_EN
  logic [15:0] hold_q;
  logic [15:0] hold_nxt;
  // While locked, every duty update also refreshes the holdover value.
  assign hold_nxt = (load_now && state_q == LOCK) ? Loop_Duty : hold_q;

  // Holdover register, tracked separately so HOLD can replay the last locked duty.
  always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
    if (!CLK_Rst) begin
      hold_q <= PWM_DUTY_HALF;
    end else begin
      hold_q <= hold_nxt;
    end
  end
`endif

  // Sequencer: state, counters, watchdog and the registered duty word.
  always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
    if (!CLK_Rst) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      good_cnt_q <= '0;
      pwm_q      <= PWM_DUTY_HALF;
      wdog_q     <= '0;
      upd_q      <= 1'b0;
    end else begin
      upd_q <= Loop_Update;
      if (load_now) begin
        pwm_q <= Loop_Duty;
      end

      // Watchdog only runs while measurements are expected.
      if (tracking || state_q == WARMUP) begin
        wdog_q <= sample ? '0 : wdog_q + 24'd1;
      end else begin
        wdog_q <= '0;
      end

      case (state_q)
        IDLE: begin
          pwm_q <= PWM_DUTY_HALF;
          if (GPS_Exist) begin
            state_q    <= WARMUP;
            samp_cnt_q <= '0;
          end
        end

        WARMUP: begin
          if (gps_loss) begin
            state_q    <= IDLE;
            pwm_q      <= PWM_DUTY_HALF;
            samp_cnt_q <= '0;
            good_cnt_q <= '0;
          end else if (sample) begin
            if (samp_cnt_q == WARM_LAST) begin
              state_q    <= TRACK;
              samp_cnt_q <= '0;
              good_cnt_q <= '0;
            end else begin
              samp_cnt_q <= samp_cnt_q + 16'd1;
            end
          end
        end

        TRACK: begin
          if (gps_loss) begin
            state_q    <= IDLE;
            pwm_q      <= PWM_DUTY_HALF;
            samp_cnt_q <= '0;
            good_cnt_q <= '0;
          end else if (sample) begin
            samp_cnt_q <= samp_cnt_q + 16'd1;
            if (good_smp) begin
              good_cnt_q <= good_inc;
              if (good_inc == LOCK_CNT) begin
                state_q    <= LOCK;
                samp_cnt_q <= '0;
              end
            end else begin
              good_cnt_q <= '0;
            end
          end
        end

        LOCK: begin
          if (gps_loss) begin
            samp_cnt_q <= '0;
            good_cnt_q <= '0;
`ifdef DISCIPLINE_HOLDOVER_EN
            state_q    <= HOLD;
            pwm_q      <= hold_nxt;
`else
            state_q    <= IDLE;
            pwm_q      <= PWM_DUTY_HALF;
`endif
          end else if (sample) begin
            if (Phase_Out > UNLOCK_TH) begin
              state_q    <= TRACK;
              samp_cnt_q <= '0;
              good_cnt_q <= '0;
            end else begin
              samp_cnt_q <= samp_cnt_q + 16'd1;
            end
          end
        end

`ifdef DISCIPLINE_HOLDOVER_EN
        HOLD: begin
          pwm_q <= hold_q;
          if (GPS_Exist) begin
            state_q    <= WARMUP;
            samp_cnt_q <= '0;
          end
        end
`endif

        default: begin
          state_q    <= IDLE;
          pwm_q      <= PWM_DUTY_HALF;
          samp_cnt_q <= '0;
          good_cnt_q <= '0;
        end
      endcase
    end
  end

  assign PWM_Duty  = pwm_q;
  assign Seq_State = state_q;
  assign Locked    = (state_q == LOCK);

endmodule

// File: tb/tb_discipline_seq.sv
// Directed, table-driven bench for discipline_seq.
// Watchdog is shortened so its expiry is reachable in a short run.
// Holdover expectations follow DISCIPLINE_HOLDOVER_EN.
module tb_discipline_seq;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WARMUP = 3'd1;
  localparam logic [2:0] S_TRACK  = 3'd2;
  localparam logic [2:0] S_LOCK   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [15:0] HALF    = 16'd32768;
  localparam int WD = 300;

`ifdef DISCIPLINE_HOLDOVER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        gps   = 1'b0;
  logic        flag  = 1'b0;
  logic        dir   = 1'b0;
  logic [15:0] phase = '0;
  logic [15:0] duty  = '0;
  logic        upd;
  logic [15:0] pwm;
  logic [2:0]  st;
  logic        locked;

  always #50 clk = ~clk;

  discipline_seq #(
    .WDOG_CYC(24'(WD))
  ) dut (
    .CLK_Sys          (clk),
    .CLK_Rst          (rst_n),
    .GPS_Exist        (gps),
    .Flag_Measure_Done(flag),
    .Flag_Measure_Dir (dir),
    .Phase_Out        (phase),
    .Loop_Duty        (duty),
    .Loop_Update      (upd),
    .PWM_Duty         (pwm),
    .Seq_State        (st),
    .Locked           (locked)
  );

  typedef struct {
    logic [15:0] phase;
    logic [15:0] duty;
    logic        pulse;
    logic [2:0]  state;
    logic [15:0] pwm;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ph, input logic [15:0] du, input logic pu,
                     input logic [2:0] s, input logic [15:0] pw);
    vec_t v;
    v.phase = ph; v.duty = du; v.pulse = pu; v.state = s; v.pwm = pw;
    vecs.push_back(v);
  endtask

  // One measurement: rise at a negedge, pulse observed in that cycle,
  // duty observed one cycle later (mid) and after the load cycle.
  task automatic run_sample(input logic [15:0] ph, input logic [15:0] du,
                            output logic pulse, output logic [15:0] pwm_mid);
    @(negedge clk);
    phase = ph;
    duty  = du;
    flag  = 1'b1;
    dir   = ph[0];
    #1 pulse = upd;
    @(negedge clk);
    pwm_mid = pwm;
    flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_n(input int n, input logic [15:0] ph, input logic [15:0] du);
    logic       p;
    logic [15:0] m;
    for (int k = 0; k < n; k++) run_sample(ph, du, p, m);
  endtask

  initial begin
    logic        p;
    logic [15:0] mid;
    logic [15:0] prev_pwm;
    logic [2:0]  loss_st;
    logic [15:0] loss_pwm;
    int          left_n;

    loss_st  = HOLD_EN ? S_HOLD : S_IDLE;
    loss_pwm = HOLD_EN ? 16'd33000 : HALF;

    // Warmup: 16 samples, no pulses, TRACK on the 16th.
    for (int i = 0; i < 16; i++) add(16'd0, 16'd33000, 1'b0, (i == 15) ? S_TRACK : S_WARMUP, HALF);
    // Phase exactly at LOCK_TH is good; LOCK on the 8th.
    for (int i = 0; i < 8; i++) add(16'd8, 16'd33000, 1'b1, (i == 7) ? S_LOCK : S_TRACK, 16'd33000);
    // Phase exactly at UNLOCK_TH keeps lock; one count above drops it.
    add(16'd200, 16'd33000, 1'b1, S_LOCK, 16'd33000);
    add(16'd201, 16'd34000, 1'b1, S_TRACK, 16'd34000);
    // good x7, one bad (9), good x8 -> LOCK only on the last.
    for (int i = 0; i < 7; i++) add(16'd8, 16'd35000, 1'b1, S_TRACK, 16'd35000);
    add(16'd9, 16'd35000, 1'b1, S_TRACK, 16'd35000);
    for (int i = 0; i < 8; i++) add(16'd3, 16'd33000, 1'b1, (i == 7) ? S_LOCK : S_TRACK, 16'd33000);

    // Reset values.
    #5 rst_n = 1'b0;
    #115;
    chk("rst_state", st, S_IDLE);
    chk("rst_pwm", pwm, HALF);
    chk("rst_upd", upd, 1'b0);
    chk("rst_locked", locked, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    gps   = 1'b1;
    @(negedge clk);
    chk("idle_to_warmup", st, S_WARMUP);

    prev_pwm = HALF;
    for (int i = 0; i < vecs.size(); i++) begin
      run_sample(vecs[i].phase, vecs[i].duty, p, mid);
      chk($sformatf("v%0d_pulse", i), p, vecs[i].pulse);
      chk($sformatf("v%0d_state", i), st, vecs[i].state);
      chk($sformatf("v%0d_pwm_mid", i), mid, prev_pwm);
      chk($sformatf("v%0d_pwm", i), pwm, vecs[i].pwm);
      chk($sformatf("v%0d_locked", i), locked, vecs[i].state == S_LOCK);
      prev_pwm = vecs[i].pwm;
    end

    // GPS loss while locked.
    @(negedge clk);
    gps = 1'b0;
    @(negedge clk);
    chk("gpsloss_state", st, loss_st);
    chk("gpsloss_pwm", pwm, loss_pwm);
    chk("gpsloss_locked", locked, 1'b0);
    gps = 1'b1;
    @(negedge clk);
    chk("regain_state", st, S_WARMUP);
    chk("regain_pwm", pwm, loss_pwm);

    // Relock, then starve of samples until the watchdog fires.
    run_n(16, 16'd0, 16'd33000);
    run_n(8, 16'd0, 16'd33000);
    chk("relock_state", st, S_LOCK);
    left_n = WD + 6;
    for (int n = 1; n <= WD + 5; n++) begin
      @(negedge clk);
      if (st != S_LOCK) begin
        left_n = n;
        break;
      end
    end
    chk("wdog_window", (left_n >= WD - 1) && (left_n <= WD + 2), 1'b1);
    chk("wdog_state", st, loss_st);
    chk("wdog_pwm", pwm, loss_pwm);

    // Coincident sample and GPS fall in TRACK: no pulse, back to IDLE.
    run_n(16, 16'd0, 16'd33000);
    chk("track_again", st, S_TRACK);
    run_sample(16'd50, 16'd36000, p, mid);
    chk("track_pulse", p, 1'b1);
    chk("track_pwm", pwm, 16'd36000);
    @(negedge clk);
    gps   = 1'b0;
    flag  = 1'b1;
    phase = 16'd0;
    #1 chk("coinc_no_pulse", upd, 1'b0);
    @(negedge clk);
    flag = 1'b0;
    chk("coinc_state", st, S_IDLE);
    @(negedge clk);
    chk("coinc_pwm", pwm, HALF);

    // Asynchronous reset while locked.
    gps = 1'b1;
    @(negedge clk);
    run_n(24, 16'd1, 16'd40000);
    chk("lock3_state", st, S_LOCK);
    chk("lock3_pwm", pwm, 16'd40000);
    @(negedge clk);
    flag  = 1'b1;
    phase = 16'd0;
    #1 chk("pre_rst_pulse", upd, 1'b1);
    #10 rst_n = 1'b0;
    #1;
    chk("arst_state", st, S_IDLE);
    chk("arst_pwm", pwm, HALF);
    chk("arst_upd", upd, 1'b0);
    chk("arst_locked", locked, 1'b0);
    @(negedge clk);
    flag = 1'b0;
    gps  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", st, S_IDLE);
    chk("post_rst_pwm", pwm, HALF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
